// File: rtl/vbus_dma_responder.sv
// ----------------------------------------------------------------------------
// vbus_dma_responder : stalls the 68000 and serves VDP VBUS DMA reads from memory
// Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module vbus_dma_responder #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int CNT_W          = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             VBUS_DMA_REQ,
   output logic             VBUS_DMA_ACK,
   input  logic             VBUS_SEL,
   input  logic [23:0]      VBUS_ADDR,
   input  logic             VBUS_UDS_N,
   input  logic             VBUS_LDS_N,
   output logic [15:0]      VBUS_DATA,
   output logic             VBUS_DTACK_N,
   input  logic             M68_AS_N,
   output logic             CPU_HALT,
   output logic             MEM_REQ,
   output logic [22:0]      MEM_ADDR,
   output logic [1:0]       MEM_BE,
   input  logic [15:0]      MEM_RDATA,
   input  logic             MEM_VALID,
   output logic [CNT_W-1:0] DMA_WORDS
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_CPU = 3'd1,
      S_GRANTED  = 3'd2,
      S_MEM_WAIT = 3'd3,
      S_ACK      = 3'd4,
      S_RELEASE  = 3'd5
   } state_t;

   state_t            state_q,   state_d;
   logic              ack_q,     ack_d;
   logic              dtack_n_q, dtack_n_d;
   logic [15:0]       data_q,    data_d;
   logic              halt_q,    halt_d;
   logic              mem_req_q, mem_req_d;
   logic [22:0]       mem_addr_q, mem_addr_d;
   logic [1:0]        mem_be_q,  mem_be_d;
   logic [CNT_W-1:0]  words_q,   words_d;
   logic [TO_W-1:0]   wait_q,    wait_d;
   logic              addr_mapped;

   // ROM occupies the bottom 4 MB, work RAM the top 2 MB; everything else reads as open bus
   assign addr_mapped = (VBUS_ADDR <= 24'h3F_FFFF) || (VBUS_ADDR >= 24'hE0_0000);

   always_comb begin
      state_d    = state_q;
      ack_d      = ack_q;
      dtack_n_d  = dtack_n_q;
      data_d     = data_q;
      halt_d     = halt_q;
      mem_req_d  = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_be_d   = mem_be_q;
      words_d    = words_q;
      wait_d     = wait_q;

      case (state_q)
         S_IDLE: begin
            if (VBUS_DMA_REQ) begin
               halt_d  = 1'b1;
               state_d = S_WAIT_CPU;
            end
         end
         S_WAIT_CPU: begin
            if (M68_AS_N) begin
               ack_d   = 1'b1;
               words_d = '0;
               state_d = S_GRANTED;
            end
         end
         S_GRANTED: begin
            if (VBUS_SEL) begin
               if (addr_mapped) begin
                  mem_addr_d = VBUS_ADDR[23:1];
                  mem_be_d   = {~VBUS_UDS_N, ~VBUS_LDS_N};
                  mem_req_d  = 1'b1;
                  wait_d     = '0;
                  state_d    = S_MEM_WAIT;
               end else begin
                  data_d  = 16'hFFFF;
                  state_d = S_ACK;
               end
            end else if (!VBUS_DMA_REQ) begin
               ack_d   = 1'b0;
               state_d = S_RELEASE;
            end
         end
         S_MEM_WAIT: begin
            if (MEM_VALID) begin
               data_d    = MEM_RDATA;
               dtack_n_d = 1'b0;
               state_d   = S_ACK;
            end else if (wait_q == TO_W'(TIMEOUT_CYCLES)) begin
               data_d    = 16'hFFFF;
               dtack_n_d = 1'b0;
               state_d   = S_ACK;
            end else begin
               wait_d = wait_q + TO_W'(1);
            end
         end
         S_ACK: begin
            // Unmapped reads enter here with DTACK still high and assert it one cycle later
            if (!VBUS_SEL) begin
               dtack_n_d = 1'b1;
               words_d   = words_q + CNT_W'(1);
               state_d   = S_GRANTED;
            end else begin
               dtack_n_d = 1'b0;
            end
         end
         S_RELEASE: begin
            halt_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         ack_q      <= 1'b0;
         dtack_n_q  <= 1'b1;
         data_q     <= 16'h0000;
         halt_q     <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_be_q   <= '0;
         words_q    <= '0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         dtack_n_q  <= dtack_n_d;
         data_q     <= data_d;
         halt_q     <= halt_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         mem_be_q   <= mem_be_d;
         words_q    <= words_d;
         wait_q     <= wait_d;
      end
   end

   assign VBUS_DMA_ACK = ack_q;
   assign VBUS_DTACK_N = dtack_n_q;
   assign VBUS_DATA    = data_q;
   assign CPU_HALT     = halt_q;
   assign MEM_REQ      = mem_req_q;
   assign MEM_ADDR     = mem_addr_q;
   assign MEM_BE       = mem_be_q;
   assign DMA_WORDS    = words_q;

endmodule

`default_nettype wire

// File: tb/tb_vbus_dma_responder.sv
// ----------------------------------------------------------------------------
// tb_vbus_dma_responder : directed bench with a behavioural model of the DMA responder
// Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vbus_dma_responder;

   localparam int TO = 15;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic          sel = 1'b0;
   logic          uds_n = 1'b1;
   logic          lds_n = 1'b1;
   logic          as_n = 1'b1;
   logic          mem_valid = 1'b0;
   logic [23:0]   addr = '0;
   logic [15:0]   rdata = '0;

   logic          ack, dtack_n, halt, mem_req;
   logic [15:0]   vdata;
   logic [22:0]   mem_addr;
   logic [1:0]    mem_be;
   logic [CW-1:0] words;

   int checks = 0;
   int errors = 0;
   int cyc;

   vbus_dma_responder #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .CLK          (clk),
      .RST          (rst),
      .VBUS_DMA_REQ (req),
      .VBUS_DMA_ACK (ack),
      .VBUS_SEL     (sel),
      .VBUS_ADDR    (addr),
      .VBUS_UDS_N   (uds_n),
      .VBUS_LDS_N   (lds_n),
      .VBUS_DATA    (vdata),
      .VBUS_DTACK_N (dtack_n),
      .M68_AS_N     (as_n),
      .CPU_HALT     (halt),
      .MEM_REQ      (mem_req),
      .MEM_ADDR     (mem_addr),
      .MEM_BE       (mem_be),
      .MEM_RDATA    (rdata),
      .MEM_VALID    (mem_valid),
      .DMA_WORDS    (words)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit is_mapped(input logic [23:0] a);
      return (a < 24'h40_0000) || (a >= 24'hE0_0000);
   endfunction

   // Behavioural model: bus ownership as a few flags, one read in flight at most
   logic        e_ack = 0, e_halt = 0, e_dtack_n = 1, e_req = 0;
   logic [15:0] e_data = 0;
   logic [22:0] e_addr = 0;
   logic [1:0]  e_be = 0;
   int          e_words = 0;
   int          waited = 0;
   bit          stalling = 0, fetching = 0, acking = 0, leaving = 0;

   always @(posedge clk) begin
      if (rst) begin
         e_ack <= 0; e_halt <= 0; e_dtack_n <= 1; e_req <= 0;
         e_data <= 0; e_addr <= 0; e_be <= 0; e_words <= 0; waited <= 0;
         stalling <= 0; fetching <= 0; acking <= 0; leaving <= 0;
      end else begin
         e_req <= 0;
         if (!e_halt) begin
            if (req) begin e_halt <= 1; stalling <= 1; end
         end else if (stalling) begin
            if (as_n) begin stalling <= 0; e_ack <= 1; e_words <= 0; end
         end else if (leaving) begin
            leaving <= 0; e_halt <= 0;
         end else if (fetching) begin
            if (mem_valid) begin
               e_data <= rdata; e_dtack_n <= 0; fetching <= 0; acking <= 1;
            end else if (waited == TO) begin
               e_data <= 16'hFFFF; e_dtack_n <= 0; fetching <= 0; acking <= 1;
            end else begin
               waited <= waited + 1;
            end
         end else if (acking) begin
            if (!sel) begin
               acking <= 0; e_dtack_n <= 1; e_words <= (e_words + 1) % (1 << CW);
            end else begin
               e_dtack_n <= 0;
            end
         end else if (sel) begin
            if (is_mapped(addr)) begin
               e_req <= 1; e_addr <= 23'(addr >> 1); e_be <= {!uds_n, !lds_n};
               fetching <= 1; waited <= 0;
            end else begin
               e_data <= 16'hFFFF; acking <= 1;
            end
         end else if (!req) begin
            e_ack <= 0; leaving <= 1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("m_ack",     ack,      e_ack);
      chk("m_halt",    halt,     e_halt);
      chk("m_dtack_n", dtack_n,  e_dtack_n);
      chk("m_data",    vdata,    e_data);
      chk("m_mem_req", mem_req,  e_req);
      chk("m_mem_addr",mem_addr, e_addr);
      chk("m_mem_be",  mem_be,   e_be);
      chk("m_words",   words,    32'(e_words[CW-1:0]));
   end

   // One VBUS read; lat < 0 means memory never answers. cyc = edges from SEL to DTACK low.
   task automatic access(input logic [23:0] a, input bit m, input int lat,
                         input logic [15:0] d, input logic [15:0] exp, output int n);
      int k;
      sel = 1; addr = a; tick; n = 1; k = 0;
      chk("acc_mem_req", mem_req, m);
      if (m) begin
         chk("acc_mem_addr", mem_addr, a[23:1]);
         chk("acc_mem_be", mem_be, {~uds_n, ~lds_n});
      end
      while (dtack_n === 1'b1 && n < 40) begin
         mem_valid = (lat >= 0 && k == lat);
         rdata = d;
         tick;
         mem_valid = 0;
         n++; k++;
      end
      chk("acc_dtack_seen", dtack_n, 0);
      chk("acc_data", vdata, exp);
      tick;
      chk("acc_dtack_hold", dtack_n, 0);
      sel = 0;
      tick;
      chk("acc_dtack_rel", dtack_n, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick; tick;
      chk("rst_ack", ack, 0);
      chk("rst_halt", halt, 0);
      chk("rst_dtack", dtack_n, 1);
      chk("rst_data", vdata, 16'h0000);
      chk("rst_words", words, 0);
      rst = 0;

      // basic grant and release
      req = 1; tick;
      chk("grant_halt", halt, 1);
      chk("grant_ack_early", ack, 0);
      tick;
      chk("grant_ack", ack, 1);
      req = 0; tick;
      chk("rel_ack", ack, 0);
      chk("rel_halt_held", halt, 1);
      tick;
      chk("rel_halt", halt, 0);

      // 68000 busy for five cycles
      as_n = 0; req = 1;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("busy_ack", ack, 0);
         chk("busy_halt", halt, 1);
      end
      as_n = 1; tick;
      chk("busy_grant", ack, 1);

      // ROM read, 3-cycle memory latency
      uds_n = 0; lds_n = 0;
      access(24'h000204, 1, 3, 16'hA55A, 16'hA55A, cyc);
      chk("rom_latency", cyc, 5);
      chk("rom_words", words, 1);

      // unmapped and timeout
      access(24'hA10000, 0, -1, 16'h0000, 16'hFFFF, cyc);
      chk("unmapped_latency", cyc, 2);
      lds_n = 1;
      access(24'hE00010, 1, -1, 16'h1234, 16'hFFFF, cyc);
      chk("timeout_latency", cyc, TO + 2);
      chk("timeout_words", words, 3);
      lds_n = 0;

      // fresh grant, then 17 reads wrap the 4-bit counter to 1
      req = 0; tick; tick;
      req = 1; tick; tick;
      chk("regrant_ack", ack, 1);
      chk("regrant_words", words, 0);
      for (int i = 0; i < 17; i++) begin
         access((i % 2) ? 24'hE00000 + 24'(2 * i) : 24'h000100 + 24'(2 * i),
                1, 1 + (i % 3), 16'h1000 + 16'(i), 16'h1000 + 16'(i), cyc);
      end
      chk("wrap_words", words, 1);

      // request dropped while the memory read is outstanding
      sel = 1; addr = 24'hFF0002; tick;
      chk("drop_mem_req", mem_req, 1);
      req = 0; tick; tick;
      mem_valid = 1; rdata = 16'hBEEF; tick; mem_valid = 0;
      chk("drop_dtack", dtack_n, 0);
      chk("drop_data", vdata, 16'hBEEF);
      chk("drop_ack_held", ack, 1);
      sel = 0; tick;
      chk("drop_dtack_rel", dtack_n, 1);
      chk("drop_ack_still", ack, 1);
      tick;
      chk("drop_ack_low", ack, 0);
      chk("drop_halt_held", halt, 1);
      tick;
      chk("drop_halt_low", halt, 0);

      // reset while waiting on memory
      req = 1; tick; tick;
      sel = 1; addr = 24'h000010; tick; tick;
      rst = 1; tick;
      chk("mrst_ack", ack, 0);
      chk("mrst_halt", halt, 0);
      chk("mrst_dtack", dtack_n, 1);
      chk("mrst_data", vdata, 0);
      chk("mrst_mem_req", mem_req, 0);
      chk("mrst_mem_addr", mem_addr, 0);
      chk("mrst_mem_be", mem_be, 0);
      chk("mrst_words", words, 0);
      rst = 0; req = 0; sel = 0;
      mem_valid = 1; rdata = 16'h5555; tick; mem_valid = 0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("late_valid_dtack", dtack_n, 1);
         chk("late_valid_data", vdata, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
